// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants for the serial adder family
package adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  function automatic logic width_ok(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - full adder cell from two half adders and an OR
module full_adder (
  input  logic In1,
  input  logic In2,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);

  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (
    .In1   (In1),
    .In2   (In2),
    .Sum   (s0),
    .Carry (c0)
  );

  half_adder u_ha1 (
    .In1   (s0),
    .In2   (Cin),
    .Sum   (Sum),
    .Carry (c1)
  );

  assign Carry = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - single-bit half adder primitive
module half_adder (
  input  logic In1,
  input  logic In2,
  output logic Sum,
  output logic Carry
);

  assign Sum   = In1 ^ In2;
  assign Carry = In1 & In2;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, start/done handshake
// Optional subtract mode (extra 'sub' port) enabled by SERIAL_ADDER_SUB_EN.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc_sr;
  logic [WIDTH-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  // Subtraction is a + ~b + 1; cin is ignored in that mode.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b;
  assign c_load = cin;
`endif

  full_adder u_fa (
    .In1   (a_sr[0]),
    .In2   (b_sr[0]),
    .Cin   (carry),
    .Sum   (fa_sum),
    .Carry (fa_carry)
  );

  assign acc_nxt  = {fa_sum, acc_sr[WIDTH-1:1]};
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      acc_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == ST_RUN);
      done  <= (state_nxt == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
          end
        end
        ST_RUN: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          acc_sr <= acc_nxt;
          carry  <= fa_carry;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= acc_nxt;
            cout <= fa_carry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder (WIDTH=8)
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                        input logic vc, input logic [7:0] es, input logic ec);
    int n;
    int nb;
    a = va; b = vb; cin = vc; start = 1'b1;
    step();
    start = 1'b0; a = ~va; b = ~vb; cin = ~vc;
    n = 1; nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 9);
    chk({tag, "_busy_cycles"}, nb, 8);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    step();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n;
    int ndone;
    int last;
    logic changed;
    logic [7:0] va[4] = '{8'h12, 8'hF0, 8'hAA, 8'h80};
    logic [7:0] vb[4] = '{8'h34, 8'h0F, 8'h55, 8'h80};
    logic       vc[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] es[4] = '{8'h46, 8'h00, 8'hFF, 8'h01};
    logic       ec[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    step();

    run_op("basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    run_op("ripple1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("ripple2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // start during RUN must be ignored; previous result FF/1 must hold
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 8'h80; b = 8'h80; start = 1'b1;
    step();
    start = 1'b0;
    changed = 1'b0; n = 0;
    while (!done && n < 40) begin
      if (sum !== 8'hFF || cout !== 1'b1) changed = 1'b1;
      step();
      n++;
    end
    chk("ign_hold", changed, 0);
    chk("ign_done_seen", done, 1);
    chk("ign_sum", sum, 8'h02);
    chk("ign_cout", cout, 0);
    ndone = 0;
    repeat (15) begin
      step();
      if (done) ndone++;
    end
    chk("ign_extra_done", ndone, 0);

    // asynchronous reset in the 4th RUN cycle
    a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    chk("abort_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", cout, 0);
    step();
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      step();
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op("after_abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // start held high: one result every WIDTH+2 cycles
    start = 1'b1;
    last = 0;
    for (int k = 0; k < 4; k++) begin
      a = va[k]; b = vb[k]; cin = vc[k];
      step();
      a = 8'h5A; b = 8'hC3; cin = ~vc[k];
      n = 1;
      while (!done && n < 40) begin
        step();
        n++;
      end
      chk($sformatf("b2b%0d_latency", k), n, 9);
      chk($sformatf("b2b%0d_sum", k), sum, es[k]);
      chk($sformatf("b2b%0d_cout", k), cout, ec[k]);
      if (k > 0) chk($sformatf("b2b%0d_period", k), cyc - last, 10);
      last = cyc;
      step();
      chk($sformatf("b2b%0d_done_pulse", k), done, 0);
    end
    start = 1'b0;
    repeat (12) step();

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    run_op("sub_noborrow", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
    run_op("sub_borrow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0);
    sub = 1'b0;
    run_op("sub_off_add", 8'h10, 8'h01, 1'b1, 8'h12, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
